// File: rtl/ccip_feature_list_pkg.sv
// CCI-P feature list types and DFH chain helper.
// Shared by the MMIO read sequencer and its request FIFO.
package ccip_feature_list_pkg;

  localparam int CCIP_MMIO_ADDR_WIDTH = 16;
  localparam int CCIP_MMIO_TID_WIDTH  = 9;

  typedef logic [11:0] t_ccip_feature_id;
  typedef logic [3:0]  t_ccip_feature_version;

  typedef enum logic [3:0] {
    eFTYP_AFU = 4'h1,
    eFTYP_BBB = 4'h2,
    eFTYP_PVT = 4'h3
  } t_ccip_feature_type;

  typedef struct packed {
    t_ccip_feature_type    f_type;
    logic [18:0]           rsvd0;
    logic                  eol;
    logic [23:0]           next;
    t_ccip_feature_version version;
    t_ccip_feature_id      id;
  } t_ccip_dfh;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FWD,
    S_WAIT,
    S_RESP
  } t_mmio_seq_state;

  function automatic t_ccip_dfh ccip_dfh_chain_entry(
    input logic [3:0]            k,
    input logic                  last,
    input t_ccip_feature_id      id,
    input t_ccip_feature_version ver,
    input logic [23:0]           region_bytes
  );
    t_ccip_dfh d;
    d         = '0;
    d.f_type  = (k == 4'd0) ? eFTYP_AFU : eFTYP_PVT;
    d.eol     = last;
    d.next    = last ? 24'd0 : region_bytes;
    d.version = ver;
    d.id      = id;
    return d;
  endfunction

endpackage

// File: rtl/ccip_mmio_req_fifo.sv
// Synchronous request FIFO holding {addr, tid}.
// Show-ahead read port; push while full is taken only with a pop.
module ccip_mmio_req_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 25
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             wr_en;
  logic             rd_en;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) &&
                   (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rd_en   = pop && !empty;
  assign wr_en   = push && (!full || rd_en);
  assign rd_data = mem[rptr[AW-1:0]];

  // pointer update
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (rd_en) rptr <= rptr + 1'b1;
    end
  end

  // storage write
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/ccip_dfh_mmio_sequencer.sv
// MMIO read sequencer for a chain of DFH feature regions.
// Serves DFH words locally, forwards CSR reads, forces timeouts.
module ccip_dfh_mmio_sequencer
  import ccip_feature_list_pkg::*;
#(
  parameter int N_FEATURES       = 4,
  parameter int REGION_ADDR_BITS = 10,
  parameter logic [N_FEATURES*12-1:0] FEATURE_IDS = '0,
  parameter logic [3:0] FEATURE_VERSION = 4'h0,
  parameter int REQ_FIFO_DEPTH   = 8,
  parameter int TIMEOUT_CYCLES   = 512
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        rd_req_valid,
  input  logic [15:0]                 rd_req_addr,
  input  logic [8:0]                  rd_req_tid,
  output logic                        rd_rsp_valid,
  output logic [8:0]                  rd_rsp_tid,
  output logic [63:0]                 rd_rsp_data,
  output logic [N_FEATURES-1:0]       fe_req_valid,
  output logic [REGION_ADDR_BITS-1:0] fe_req_addr,
  input  logic [N_FEATURES-1:0]       fe_rsp_valid,
  input  logic [N_FEATURES*64-1:0]    fe_rsp_data,
  output logic                        busy,
  output logic                        overflow,
  output logic [15:0]                 timeout_count
);

  localparam int AW = CCIP_MMIO_ADDR_WIDTH;
  localparam int TW = CCIP_MMIO_TID_WIDTH;
  localparam int RB = REGION_ADDR_BITS;
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [23:0] REGION_BYTES = 24'(64'd4 << RB);
  localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT_CYCLES - 1);

  t_mmio_seq_state state, state_n;

  logic          pop;
  logic          full;
  logic          empty;
  logic [AW+TW-1:0] head;
  logic [AW-1:0] head_addr;
  logic [TW-1:0] head_tid;

  logic [3:0]    dk;
  logic [RB-1:0] doff;
  logic          oor;
  logic          dfh_hit;
  t_ccip_feature_id id_sel;
  t_ccip_dfh     dfh_word;

  logic [3:0]    k_q, k_n;
  logic [RB-1:0] off_q, off_n;
  logic [TW-1:0] tid_q, tid_n;
  logic [63:0]   data_q, data_n;
  logic [CW-1:0] timer_q, timer_n;
  logic [15:0]   tcnt_q, tcnt_n;
  logic          ovf_q, ovf_n;

  logic          fe_hit;
  logic [63:0]   fe_sel;

  ccip_mmio_req_fifo #(
    .DEPTH (REQ_FIFO_DEPTH),
    .WIDTH (AW + TW)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (rd_req_valid),
    .wr_data ({rd_req_addr, rd_req_tid}),
    .pop     (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty)
  );

  assign head_addr = head[AW+TW-1:TW];
  assign head_tid  = head[TW-1:0];

  if (RB + 4 < AW) begin : g_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^head_addr[AW-1:RB+4];
  end

  // decode of the request at the FIFO head, including its DFH word
  always_comb begin
    dk      = head_addr[RB +: 4];
    doff    = head_addr[RB-1:0];
    oor     = ({1'b0, dk} >= 5'(N_FEATURES));
    dfh_hit = (doff[RB-1:1] == '0);
    id_sel  = '0;
    for (int i = 0; i < N_FEATURES; i++) begin
      if (dk == 4'(i)) id_sel = FEATURE_IDS[i*12 +: 12];
    end
    dfh_word = ccip_dfh_chain_entry(dk,
                                    dk == 4'(N_FEATURES - 1),
                                    id_sel, FEATURE_VERSION,
                                    REGION_BYTES);
  end

  // response lane of the feature owning the in-flight request
  always_comb begin
    fe_hit = 1'b0;
    fe_sel = '0;
    for (int i = 0; i < N_FEATURES; i++) begin
      if (k_q == 4'(i)) begin
        fe_hit = fe_rsp_valid[i];
        fe_sel = fe_rsp_data[i*64 +: 64];
      end
    end
  end

  // next-state, datapath capture and FIFO pop
  always_comb begin
    state_n = state;
    pop     = 1'b0;
    k_n     = k_q;
    off_n   = off_q;
    tid_n   = tid_q;
    data_n  = data_q;
    timer_n = timer_q;
    tcnt_n  = tcnt_q;
    unique case (state)
      S_IDLE: begin
        if (!empty) begin
          pop   = 1'b1;
          tid_n = head_tid;
          k_n   = dk;
          off_n = doff;
          if (oor) begin
            data_n  = '0;
            state_n = S_RESP;
          end else if (dfh_hit) begin
            data_n  = dfh_word;
            state_n = S_RESP;
          end else begin
            state_n = S_FWD;
          end
        end
      end
      S_FWD: begin
        timer_n = '0;
        state_n = S_WAIT;
      end
      S_WAIT: begin
        if (fe_hit) begin
          data_n  = fe_sel;
          state_n = S_RESP;
        end else if (timer_q == T_LAST) begin
          data_n  = '1;
          if (tcnt_q != 16'hFFFF) tcnt_n = tcnt_q + 16'd1;
          state_n = S_RESP;
        end else begin
          timer_n = timer_q + CW'(1);
        end
      end
      S_RESP: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    ovf_n = ovf_q | (rd_req_valid && full && !pop);
  end

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      k_q     <= '0;
      off_q   <= '0;
      tid_q   <= '0;
      data_q  <= '0;
      timer_q <= '0;
      tcnt_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state   <= state_n;
      k_q     <= k_n;
      off_q   <= off_n;
      tid_q   <= tid_n;
      data_q  <= data_n;
      timer_q <= timer_n;
      tcnt_q  <= tcnt_n;
      ovf_q   <= ovf_n;
    end
  end

  // one-hot forward strobe toward the owning feature
  always_comb begin
    fe_req_valid = '0;
    for (int i = 0; i < N_FEATURES; i++) begin
      fe_req_valid[i] = (state == S_FWD) && (k_q == 4'(i));
    end
  end

  assign fe_req_addr   = (state == S_FWD) ? off_q : '0;
  assign rd_rsp_valid  = (state == S_RESP);
  assign rd_rsp_tid    = rd_rsp_valid ? tid_q : '0;
  assign rd_rsp_data   = rd_rsp_valid ? data_q : '0;
  assign busy          = !empty || (state != S_IDLE);
  assign overflow      = ovf_q;
  assign timeout_count = tcnt_q;

endmodule

// File: tb/tb_ccip_dfh_mmio_sequencer.sv
// Directed bench for the DFH MMIO read sequencer.
// Hand-computed DFH words, latencies and timeout behaviour.
module tb_ccip_dfh_mmio_sequencer;

  logic         clk = 1'b0;
  logic         reset;
  logic         rd_req_valid;
  logic [15:0]  rd_req_addr;
  logic [8:0]   rd_req_tid;
  logic         rd_rsp_valid;
  logic [8:0]   rd_rsp_tid;
  logic [63:0]  rd_rsp_data;
  logic [3:0]   fe_req_valid;
  logic [9:0]   fe_req_addr;
  logic [3:0]   fe_rsp_valid;
  logic [255:0] fe_rsp_data;
  logic         busy;
  logic         overflow;
  logic [15:0]  timeout_count;

  always #5 clk = ~clk;

  ccip_dfh_mmio_sequencer #(
    .N_FEATURES       (4),
    .REGION_ADDR_BITS (10),
    .FEATURE_IDS      ({12'h013, 12'h012, 12'h011, 12'h010}),
    .FEATURE_VERSION  (4'h0),
    .REQ_FIFO_DEPTH   (8),
    .TIMEOUT_CYCLES   (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .rd_req_valid  (rd_req_valid),
    .rd_req_addr   (rd_req_addr),
    .rd_req_tid    (rd_req_tid),
    .rd_rsp_valid  (rd_rsp_valid),
    .rd_rsp_tid    (rd_rsp_tid),
    .rd_rsp_data   (rd_rsp_data),
    .fe_req_valid  (fe_req_valid),
    .fe_req_addr   (fe_req_addr),
    .fe_rsp_valid  (fe_rsp_valid),
    .fe_rsp_data   (fe_rsp_data),
    .busy          (busy),
    .overflow      (overflow),
    .timeout_count (timeout_count)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int fe_cnt = 0;

  int          q_cyc[$];
  logic [8:0]  q_tid[$];
  logic [63:0] q_data[$];

  logic [63:0] dfh_exp [4];

  always @(posedge clk) cyc++;

  // response and forward-strobe recorder, mid-cycle
  always @(negedge clk) begin
    if (rd_rsp_valid) begin
      q_cyc.push_back(cyc);
      q_tid.push_back(rd_rsp_tid);
      q_data.push_back(rd_rsp_data);
    end
    if (fe_req_valid != 4'b0) fe_cnt++;
  end

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int rc(input int i);
    return (i < q_cyc.size()) ? q_cyc[i] : -1;
  endfunction

  function automatic logic [8:0] rt(input int i);
    return (i < q_tid.size()) ? q_tid[i] : 9'h1FF;
  endfunction

  function automatic logic [63:0] rd(input int i);
    return (i < q_data.size()) ? q_data[i] : 64'hBAD0_BAD0_BAD0_BAD0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] a, input logic [8:0] id);
    rd_req_valid = 1'b1;
    rd_req_addr  = a;
    rd_req_tid   = id;
    tick();
    rd_req_valid = 1'b0;
  endtask

  task automatic wait_fe();
    for (int i = 0; i < 10; i++) begin
      if (fe_req_valid != 4'b0) break;
      tick();
    end
  endtask

  initial begin
    int t;
    int n0;
    int f0;
    int c;

    dfh_exp[0] = 64'h1000_0000_1000_0010;
    dfh_exp[1] = 64'h3000_0000_1000_0011;
    dfh_exp[2] = 64'h3000_0000_1000_0012;
    dfh_exp[3] = 64'h3000_0100_0000_0013;

    reset        = 1'b1;
    rd_req_valid = 1'b0;
    rd_req_addr  = '0;
    rd_req_tid   = '0;
    fe_rsp_valid = '0;
    fe_rsp_data  = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    check("rst_rsp_valid", rd_rsp_valid, 0);
    check("rst_fe_valid", fe_req_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overflow", overflow, 0);
    check("rst_tcount", timeout_count, 0);

    // DFH reads of every region, back to back
    n0 = q_cyc.size();
    f0 = fe_cnt;
    t  = cyc;
    send(16'h0000, 9'd1);
    send(16'h0400, 9'd2);
    send(16'h0800, 9'd3);
    send(16'h0C00, 9'd4);
    repeat (12) tick();
    check("dfh_count", q_cyc.size() - n0, 4);
    for (int i = 0; i < 4; i++) begin
      check("dfh_tid", rt(n0 + i), 9'(i + 1));
      check("dfh_data", rd(n0 + i), dfh_exp[i]);
      check("dfh_cyc", rc(n0 + i), t + 2 + 2 * i);
    end
    check("dfh_no_fwd", fe_cnt - f0, 0);

    // out-of-range region
    n0 = q_cyc.size();
    f0 = fe_cnt;
    t  = cyc;
    send(16'h1000, 9'd5);
    repeat (6) tick();
    check("oor_count", q_cyc.size() - n0, 1);
    check("oor_data", rd(n0), 0);
    check("oor_tid", rt(n0), 5);
    check("oor_cyc", rc(n0), t + 2);
    check("oor_no_fwd", fe_cnt - f0, 0);

    // forwarded read answered after 3 cycles
    fe_rsp_data = {64'h4444, 64'h3333, 64'hDEAD, 64'h1111};
    n0 = q_cyc.size();
    t  = cyc;
    send(16'h0402, 9'd7);
    wait_fe();
    check("fwd_vec", fe_req_valid, 4'b0010);
    check("fwd_addr", fe_req_addr, 2);
    check("fwd_cyc", cyc, t + 2);
    c = cyc;
    repeat (3) tick();
    fe_rsp_valid = 4'b0010;
    tick();
    fe_rsp_valid = 4'b0000;
    repeat (4) tick();
    check("fwd_count", q_cyc.size() - n0, 1);
    check("fwd_data", rd(n0), 64'hDEAD);
    check("fwd_tid", rt(n0), 7);
    check("fwd_rsp_cyc", rc(n0), c + 4);

    // forwarded read that is never answered
    n0 = q_cyc.size();
    t  = cyc;
    send(16'h0802, 9'd9);
    repeat (24) tick();
    check("to_count", q_cyc.size() - n0, 1);
    check("to_data", rd(n0), 64'hFFFF_FFFF_FFFF_FFFF);
    check("to_tid", rt(n0), 9);
    check("to_cyc", rc(n0), t + 19);
    check("to_tcount", timeout_count, 1);
    n0 = q_cyc.size();
    fe_rsp_valid = 4'b0100;
    tick();
    fe_rsp_valid = 4'b0000;
    repeat (4) tick();
    check("stray_count", q_cyc.size() - n0, 0);
    check("stray_busy", busy, 0);

    // flood while the FSM is stuck waiting on a feature
    n0 = q_cyc.size();
    f0 = fe_cnt;
    send(16'h0404, 9'h020);
    for (int i = 1; i < 10; i++) send(16'h0C00, 9'(32 + i));
    check("ovf_flag", overflow, 1);
    repeat (40) tick();
    check("ovf_count", q_cyc.size() - n0, 9);
    for (int i = 0; i < 9; i++) begin
      check("ovf_tid", rt(n0 + i), 9'(32 + i));
    end
    check("ovf_first_data", rd(n0), 64'hFFFF_FFFF_FFFF_FFFF);
    check("ovf_last_data", rd(n0 + 8), dfh_exp[3]);
    check("ovf_tcount", timeout_count, 2);
    check("ovf_fwd", fe_cnt - f0, 1);
    check("ovf_busy", busy, 0);

    // reset while waiting on a feature
    n0 = q_cyc.size();
    send(16'h0406, 9'h030);
    wait_fe();
    check("rw_fwd_vec", fe_req_valid, 4'b0010);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rw_busy", busy, 0);
    check("rw_overflow", overflow, 0);
    check("rw_tcount", timeout_count, 0);
    check("rw_rsp_valid", rd_rsp_valid, 0);
    repeat (25) tick();
    check("rw_no_rsp", q_cyc.size() - n0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ccip_dfh_mmio_sequencer.md
Name: ccip_dfh_mmio_sequencer

Overview:
Owns the AFU's MMIO read path for a chain of N_FEATURES feature regions laid out back-to-back from MMIO offset 0. It buffers host MMIO read requests and serves them one at a time: reads at region offset 0 return an internally generated DFH, and all other in-region reads are forwarded to the owning feature's CSR block. A timeout guarantees every request gets exactly one response. It sits between the CCI-P MMIO shim and the per-feature CSR blocks.

Parameters:
N_FEATURES, 4, number of chained feature regions (1..16)
REGION_ADDR_BITS, 10, region size in 4B words as log2 (10 = 4 KB)
FEATURE_IDS, all zero, packed N_FEATURES x t_ccip_feature_id, DFH id per region
FEATURE_VERSION, 0, DFH version field for all regions
REQ_FIFO_DEPTH, 8, request buffer entries (power of 2, >=2)
TIMEOUT_CYCLES, 512, cycles waited in WAIT before a forced response

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
rd_req_valid  in  1  host MMIO read request (no backpressure)
rd_req_addr  in  16  4B-word address; bit0 ignored (64-bit reads)
rd_req_tid  in  9  CCI-P transaction ID
rd_rsp_valid  out  1  one-cycle response strobe
rd_rsp_tid  out  9  echoed tid
rd_rsp_data  out  64  read data
fe_req_valid  out  N_FEATURES  one-hot, one-cycle forward strobe
fe_req_addr  out  REGION_ADDR_BITS  word offset within region
fe_rsp_valid  in  N_FEATURES  feature read-data strobe
fe_rsp_data  in  N_FEATURES*64  per-feature read data
busy  out  1  FIFO non-empty or FSM not IDLE
overflow  out  1  sticky: a request was dropped on a full FIFO
timeout_count  out  16  saturating count of timeouts

Behaviour:
- Reset: all outputs 0; FIFO empty; state IDLE; sticky flag and counter cleared. Reset mid-WAIT abandons the request with no response.
- Decode: k = addr[REGION_ADDR_BITS +: 4]; off = addr[REGION_ADDR_BITS-1:0].
  - k >= N_FEATURES: out-of-range, data 0.
  - off[REGION_ADDR_BITS-1:1] == 0: DFH hit.
  - Otherwise: forward to feature k.
- DFH word for region k:
  - f_type = eFTYP_AFU when k == 0, else eFTYP_PVT.
  - id = FEATURE_IDS[k]; version = FEATURE_VERSION.
  - For k < N_FEATURES-1: nextFeature = 4 << REGION_ADDR_BITS (byte offset), eol = 0.
  - For the last region: nextFeature = 0, eol = 1.
  - rsvd0 = 0.
- FIFO: push on rd_req_valid when not full. When full, the request is dropped and overflow is set. Push and pop in the same cycle are legal when full, and the new request is accepted.
- FSM:
  - IDLE: if FIFO non-empty, pop and decode. DFH or out-of-range goes to RESP with data latched. Forward goes to FWD.
  - FWD: drive fe_req_valid[k] = 1 and fe_req_addr = off for one cycle; clear the timer; go to WAIT.
  - WAIT: fe_rsp_valid[k] latches fe_rsp_data[k] and goes to RESP. Timer reaching TIMEOUT_CYCLES-1 latches 64'hFFFF_FFFF_FFFF_FFFF, increments timeout_count (saturating at 16'hFFFF) and goes to RESP. fe_rsp_valid on any other index is ignored.
  - RESP: rd_rsp_valid = 1 with the latched tid and data for exactly one cycle; go to IDLE.
- fe_rsp_valid seen outside WAIT is ignored. A late response after a timeout is discarded.
- Latency: request at cycle t gives a DFH or out-of-range response at t+2, with back-to-back service every 2 cycles. A forwarded request with feature latency L (fe_req_valid to fe_rsp_valid) gives a response at t+3+L.
- Responses are returned strictly in request order.

Decomposition:
- ccip_feature_list_pkg gains ccip_dfh_chain_entry(k, last, id, ver, region_bytes) returning t_ccip_dfh, plus CCIP_MMIO_ADDR_WIDTH = 16 and CCIP_MMIO_TID_WIDTH = 9.
- One sub-module: ccip_mmio_req_fifo (synchronous FIFO of {addr, tid}, with full and empty outputs).

Test Plan:
- N=4, REGION_ADDR_BITS=10, IDS={h10,h11,h12,h13}. Reads at addr 0, h400, h800, hC00 with tids 1..4 -> four responses in order at t+2, +4, +6, +8. Last response has eol=1, next=0, id=h13. Region 0 has f_type=1 and next=h1000.
- Read at addr h1000 (k=4) -> data 0 at t+2; no fe_req_valid.
- Read at addr h402 tid 7, feature 1 responds 3 cycles after fe_req_valid with hDEAD -> fe_req_valid=4'b0010 and fe_req_addr=2; rsp data hDEAD with tid 7 at t+6.
- Forwarded read that is never answered, TIMEOUT=16 -> data all-ones and timeout_count=1. A later stray fe_rsp_valid produces no response.
- 10 back-to-back requests into DEPTH=8 while the FSM is blocked in WAIT -> overflow=1, 9 responses (first in flight + 8), 10th dropped.
- Assert reset during WAIT -> no rd_rsp_valid; busy=0, overflow=0 and timeout_count=0 the next cycle.
